// File: rtl/snd_bus_pkg.sv
// Shared constants and decode helper for the sound-board CPU bus front end.
// No logic or latency; no flow control.
// Used by the 7442 decoder and by snd_bus_ram.
package snd_bus_pkg;

    localparam int          DEC_W    = 10;
    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam int          PIA_A10  = 10;
    localparam logic [15:0] ROM_BASE = 16'hF000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Decoder input from the top address nibble: the A15 inversion maps 0x0xxx to output 8.
    function automatic logic [3:0] dec_sel(input logic [3:0] hi);
        return {~hi[3], hi[2:0]};
    endfunction

    localparam int DEC_LO  = 0;
    localparam int DEC_RAM = int'(dec_sel(RAM_BASE[15:12]));
    localparam int DEC_ROM = int'(dec_sel(ROM_BASE[15:12]));

endpackage

// File: rtl/bcd_dec_7442.sv
// BCD 1-of-10 decoder with active-low outputs; codes 10..15 leave every output high.
// Latency: combinational.
// Backpressure: none.
module bcd_dec_7442
    import snd_bus_pkg::*;
(
    input  logic [3:0]       d,
    output logic [DEC_W-1:0] dec_n
);

    always_comb begin
        dec_n = '1;
        for (int k = 0; k < DEC_W; k++) begin
            dec_n[k] = (d != 4'(k));
        end
    end

endmodule

// File: rtl/snd_bus_ram.sv
// Sound CPU bus front end: 7442 decode, RAM/PIA/ROM selects, mirrored scratch RAM, read mux.
// Latency: selects and read data combinational; RAM writes land on the next rising clk.
// Backpressure: none; busy flags the optional RAM_CLEAR_ON_RESET_EN sweep, during which CPU writes are dropped.
module snd_bus_ram
    import snd_bus_pkg::*;
#(
    parameter int RAM_AW = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      addr,
    input  logic             vma,
    input  logic             rw,
    input  logic [7:0]       wdata,
    input  logic [7:0]       pia_rdata,
    input  logic [7:0]       rom_rdata,
    output logic [7:0]       rdata,
    output logic             ram_cs,
    output logic             pia_cs,
    output logic             rom_cs,
    output logic [DEC_W-1:0] dec_n,
    output logic             busy
);

    logic [7:0]        mem [2**RAM_AW];
    logic [7:0]        ram_q;
    logic [RAM_AW-1:0] ram_idx;
    logic              cpu_we;
    logic              unused_addr;

    bcd_dec_7442 u_dec (
        .d     (dec_sel(addr[15:12])),
        .dec_n (dec_n)
    );

    // The RAM window is 256 bytes but the array is smaller, so upper offset bits alias.
    assign unused_addr = &{1'b0, addr[7]};
    assign ram_idx     = addr[RAM_AW-1:0];

    assign ram_cs = (addr[11:8] == RAM_BASE[11:8]) & ~dec_n[DEC_RAM] & vma;
    assign pia_cs = ~(dec_n[DEC_LO] & dec_n[DEC_RAM]) & addr[PIA_A10] & vma;
    assign rom_cs = ~dec_n[DEC_ROM] & vma;

    assign ram_q  = mem[ram_idx];
    assign cpu_we = ram_cs & ~rw & ~busy & rst_n;

    always_comb begin
        rdata = rom_rdata;
        if (pia_cs) begin
            rdata = pia_rdata;
        end else if (ram_cs) begin
            rdata = ram_q;
        end
    end

`ifdef RAM_CLEAR_ON_RESET_EN
    clr_state_t        state;
    logic [RAM_AW-1:0] clr_ptr;
    logic              clr_we;

    // Reset parks the sweep at address 0; it starts walking on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + RAM_AW'(1);
                    if (clr_ptr == '1) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we = (state == ST_CLEAR) & rst_n;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr] <= '0;
        end else if (cpu_we) begin
            mem[ram_idx] <= wdata;
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem[ram_idx] <= wdata;
        end
    end
`endif

endmodule

// File: tb/tb_snd_bus_ram.sv
// Self-checking bench for snd_bus_ram: fixed vector table, hand sequences and random bus traffic
// compared against an address-range/byte-array model of the sound CPU memory map.
module tb_snd_bus_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        vma = 1'b0;
    logic        rw = 1'b1;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  pia_rdata = 8'h00;
    logic [7:0]  rom_rdata = 8'h00;
    logic [7:0]  rdata;
    logic        ram_cs, pia_cs, rom_cs, busy;
    logic [9:0]  dec_n;

    int   checks = 0;
    int   failures = 0;
    logic exp_busy = 1'b0;
    logic [7:0] mdl_mem [128];
    logic       mdl_vld [128];

    always #5 clk = ~clk;

    snd_bus_ram #(.RAM_AW(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .vma       (vma),
        .rw        (rw),
        .wdata     (wdata),
        .pia_rdata (pia_rdata),
        .rom_rdata (rom_rdata),
        .rdata     (rdata),
        .ram_cs    (ram_cs),
        .pia_cs    (pia_cs),
        .rom_cs    (rom_cs),
        .dec_n     (dec_n),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic        v;
        logic [7:0]  p;
        logic [7:0]  r;
        logic        e_ram;
        logic        e_pia;
        logic        e_rom;
        logic [7:0]  e_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Memory map from the address ranges: RAM 0000-00FF, PIA a15..12 in {0,8} with a10, ROM F000-FFFF.
    function automatic logic mdl_ram_cs(input logic [15:0] a, input logic v);
        return v && (a < 16'h0100);
    endfunction

    function automatic logic mdl_pia_cs(input logic [15:0] a, input logic v);
        return v && (a[15:12] == 4'h0 || a[15:12] == 4'h8) && a[10];
    endfunction

    function automatic logic mdl_rom_cs(input logic [15:0] a, input logic v);
        return v && (a >= 16'hF000);
    endfunction

    function automatic logic [9:0] mdl_dec(input logic [15:0] a);
        int         idx;
        logic [9:0] r;
        idx = (int'(a[15:12]) + 8) % 16;
        r = 10'h3FF;
        if (idx < 10) r[idx] = 1'b0;
        return r;
    endfunction

    task automatic drive(input logic [15:0] a, input logic v, input logic r,
                         input logic [7:0] w, input logic [7:0] p, input logic [7:0] ro);
        @(negedge clk);
        addr = a;
        vma = v;
        rw = r;
        wdata = w;
        pia_rdata = p;
        rom_rdata = ro;
    endtask

    task automatic check_bus(input string tag);
        logic       e_ram, e_pia, e_rom;
        logic [7:0] e_rd;
        int         idx;
        #1;
        e_ram = mdl_ram_cs(addr, vma);
        e_pia = mdl_pia_cs(addr, vma);
        e_rom = mdl_rom_cs(addr, vma);
        idx = int'(addr[6:0]);
        chk({tag, " ram_cs"}, 32'(ram_cs), 32'(e_ram));
        chk({tag, " pia_cs"}, 32'(pia_cs), 32'(e_pia));
        chk({tag, " rom_cs"}, 32'(rom_cs), 32'(e_rom));
        chk({tag, " dec_n"}, 32'(dec_n), 32'(mdl_dec(addr)));
        chk({tag, " busy"}, 32'(busy), 32'(exp_busy));
        if (e_pia) e_rd = pia_rdata;
        else if (e_ram) e_rd = mdl_mem[idx];
        else e_rd = rom_rdata;
        if (e_pia || !e_ram || mdl_vld[idx]) chk({tag, " rdata"}, 32'(rdata), 32'(e_rd));
        if (e_ram && !rw && rst_n && !exp_busy) begin
            mdl_mem[idx] = wdata;
            mdl_vld[idx] = 1'b1;
        end
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 128; i++) begin
            mdl_mem[i] = 8'h00;
            mdl_vld[i] = 1'b1;
        end
    endtask

    initial begin
        vec_t       tbl[10];
        logic [15:0] a;
        logic [9:0]  e_dec;
        logic [7:0]  saved;
        int          n;

        for (int i = 0; i < 128; i++) mdl_vld[i] = 1'b0;

        tbl[0] = '{16'hF123, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C};
        tbl[1] = '{16'hF123, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[2] = '{16'h0402, 1'b1, 8'h96, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h96};
        tbl[3] = '{16'h8403, 1'b1, 8'h69, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h69};
        tbl[4] = '{16'h0100, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[5] = '{16'h0FFF, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 8'h12};
        tbl[6] = '{16'h8000, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h34};
        tbl[7] = '{16'hE000, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h34};
        tbl[8] = '{16'h0402, 1'b0, 8'h96, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[9] = '{16'hFFFF, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA};

        // Reset state: selects stay combinational while rst_n is low.
`ifdef RAM_CLEAR_ON_RESET_EN
        exp_busy = 1'b1;
`endif
        drive(16'hF000, 1'b1, 1'b1, 8'h00, 8'h11, 8'h22);
        check_bus("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef RAM_CLEAR_ON_RESET_EN
        wait_clear(n);
        chk("clear_len_por", 32'(n), 32'd128);
        exp_busy = 1'b0;
        model_zero();
`endif

        for (int i = 0; i < 128; i++) begin
            drive(16'(i), 1'b1, 1'b0, 8'($urandom), 8'h00, 8'h00);
            check_bus("fill");
        end

        // Write then read back through the base and the mirror address.
        drive(16'h0010, 1'b1, 1'b0, 8'h5A, 8'h00, 8'hEE);
        check_bus("wr_0010");
        drive(16'h0010, 1'b1, 1'b1, 8'h00, 8'h00, 8'hEE);
        check_bus("rd_0010");
        chk("rd_0010 value", 32'(rdata), 32'h5A);
        drive(16'h0090, 1'b1, 1'b1, 8'h00, 8'h00, 8'hEE);
        check_bus("rd_0090");
        chk("rd_0090 value", 32'(rdata), 32'h5A);
        chk("rd_0090 ram_cs", 32'(ram_cs), 32'd1);

        // Same-cycle write shows the old byte until the edge.
        drive(16'h0010, 1'b1, 1'b0, 8'hA7, 8'h00, 8'hEE);
        #1;
        chk("rw_same old", 32'(rdata), 32'h5A);
        check_bus("rw_same");

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].a, tbl[i].v, 1'b1, 8'h00, tbl[i].p, tbl[i].r);
            #1;
            chk($sformatf("tbl%0d ram_cs", i), 32'(ram_cs), 32'(tbl[i].e_ram));
            chk($sformatf("tbl%0d pia_cs", i), 32'(pia_cs), 32'(tbl[i].e_pia));
            chk($sformatf("tbl%0d rom_cs", i), 32'(rom_cs), 32'(tbl[i].e_rom));
            chk($sformatf("tbl%0d rdata", i), 32'(rdata), 32'(tbl[i].e_rd));
        end

        for (int d = 0; d < 16; d++) begin
            a = {4'(d ^ 8), 12'h123};
            drive(a, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
            #1;
            e_dec = 10'h3FF;
            if (d < 10) e_dec[d] = 1'b0;
            chk($sformatf("dec d=%0d", d), 32'(dec_n), 32'(e_dec));
        end

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: a = {8'h00, 8'($urandom)};
                1: a = {($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, 12'($urandom)};
                2: a = {4'hF, 12'($urandom)};
                default: a = 16'($urandom);
            endcase
            drive(a, $urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0,
                  8'($urandom), 8'($urandom), 8'($urandom));
            check_bus("rand");
        end

        // Writes attempted while reset is held must not land.
        saved = mdl_mem[32];
        drive(16'h0020, 1'b1, 1'b0, ~saved, 8'h00, 8'h00);
        rst_n = 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
        exp_busy = 1'b1;
`endif
        check_bus("rst_wr");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rw = 1'b1;
`ifdef RAM_CLEAR_ON_RESET_EN
        wait_clear(n);
        chk("clear_len_rst", 32'(n), 32'd128);
        exp_busy = 1'b0;
        model_zero();
        saved = 8'h00;
`endif
        drive(16'h0020, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        check_bus("rst_rd");
        chk("rst_rd value", 32'(rdata), 32'(saved));

`ifdef RAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 128; i++) begin
            drive(16'(i), 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
            check_bus("fill_ff");
        end
        drive(16'h0000, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("clear_mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(n);
        chk("clear_len_restart", 32'(n), 32'd128);
        model_zero();
        for (int i = 0; i < 128; i++) begin
            drive(16'(i), 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
            check_bus("cleared");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
